// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   WIDTH-bit bitwise logic unit (NAND, AND, OR, NOR, XOR, XNOR, NOT-A, PASS-A)
//   followed by a STAGES-deep elastic valid/ready pipeline. Op 0 is NAND,
//   so the block can stand in for an array of NAND primitives with a
//   registered, back-pressured result.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   in_valid / in_ready  upstream handshake (accept = in_valid & in_ready)
//   in_op, in_a, in_b    operation select and operands
//   out_valid/out_ready  downstream handshake (deliver = out_valid & out_ready)
//   out_y                result, straight from the last stage register
//   op_count             wrapping count of delivered results
//   out_zero, out_ones   result flags, present only with LOGIC_UNIT_PIPE_FLAGS_EN
//
// Optional feature macro: LOGIC_UNIT_PIPE_FLAGS_EN
module logic_unit_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_ones
`endif
);

    typedef enum logic [2:0] {
        OP_NAND = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0][WIDTH-1:0] data;
    logic [STAGES:0]              rdy;
    logic [WIDTH-1:0]             res;

    always_comb begin
        res = '0;
        case (op_e'(in_op))
            OP_NAND: res = ~(in_a & in_b);
            OP_AND:  res = in_a & in_b;
            OP_OR:   res = in_a | in_b;
            OP_NOR:  res = ~(in_a | in_b);
            OP_XOR:  res = in_a ^ in_b;
            OP_XNOR: res = ~(in_a ^ in_b);
            OP_NOTA: res = ~in_a;
            OP_PASS: res = in_a;
            default: res = '0;
        endcase
    end

    // ready_k = ~valid_k | ready_{k+1} unrolled: a stage can load if any
    // stage from it to the output is empty, or the output is being taken.
    assign rdy[STAGES] = out_ready;
    for (genvar k = 0; k < STAGES; k++) begin : g_rdy
        assign rdy[k] = out_ready | ~(&vld[STAGES-1:k]);
    end

    // Reads 1 throughout reset even when the pipe was full; no accept happens
    // then because the reset branch below overrides every load.
    assign in_ready  = rdy[0] | reset;
    assign out_valid = vld[STAGES-1];
    assign out_y     = data[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld[0]   <= 1'b0;
            data[0]  <= '0;
            op_count <= '0;
        end else begin
            if (rdy[0]) begin
                vld[0] <= in_valid;
                if (in_valid) data[0] <= res;
            end
            if (out_valid && out_ready) op_count <= op_count + 1'b1;
        end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        always_ff @(posedge clk) begin
            if (reset) begin
                vld[k]  <= 1'b0;
                data[k] <= '0;
            end else if (rdy[k]) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) data[k] <= data[k-1];
            end
        end
    end

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    logic [STAGES-1:0] zf;
    logic [STAGES-1:0] of;

    assign out_zero = zf[STAGES-1];
    assign out_ones = of[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            zf[0] <= 1'b0;
            of[0] <= 1'b0;
        end else if (rdy[0] && in_valid) begin
            zf[0] <= (res == '0);
            of[0] <= (res == '1);
        end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_flag
        always_ff @(posedge clk) begin
            if (reset) begin
                zf[k] <= 1'b0;
                of[k] <= 1'b0;
            end else if (rdy[k] && vld[k-1]) begin
                zf[k] <= zf[k-1];
                of[k] <= of[k-1];
            end
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic [15:0] op_count;

    logic        in_ready_c;
    logic        out_valid_c;
    logic [15:0] out_y_c;
    logic [3:0]  op_count_c;

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    logic out_zero, out_ones, out_zero_c, out_ones_c;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] tt [8];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(16), .STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .op_count(op_count)
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        , .out_zero(out_zero), .out_ones(out_ones)
`endif
    );

    // Same stimulus, narrow counter, for the wrap checks.
    logic_unit_pipe #(.WIDTH(16), .STAGES(2), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_c),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid_c), .out_ready(out_ready),
        .out_y(out_y_c), .op_count(op_count_c)
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        , .out_zero(out_zero_c), .out_ones(out_ones_c)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tt = '{16'h0FFF, 16'hF000, 16'hFFF0, 16'h000F,
               16'h0FF0, 16'hF00F, 16'h0F0F, 16'hF0F0};

        // ---------------- reset ----------------
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 3'd0; in_a = 16'hF0F0; in_b = 16'hFF00;
        tick();
        @(negedge clk);
        check("rst_in_ready_during", in_ready, 1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_op_count", op_count, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        check("rst_out_zero", out_zero, 0);
        check("rst_out_ones", out_ones, 0);
`endif
        tick();

        // ---------------- truth table, ops 0..7 back-to-back ----------------
        for (int c = 0; c < 11; c++) begin
            in_valid = (c < 8);
            in_op    = 3'(c);
            @(negedge clk);
            if (c < 8) check("tt_in_ready", in_ready, 1);
            if (c >= 2 && c < 10) begin
                check("tt_out_valid", out_valid, 1);
                check("tt_out_y", out_y, tt[c-2]);
            end
            if (c == 10) begin
                check("tt_drained", out_valid, 0);
                check("tt_op_count", op_count, 8);
            end
            tick();
        end

        // ---------------- back-pressure ----------------
        out_ready = 1'b0; in_valid = 1'b1;
        in_op = 3'd1;                                   // F000
        @(negedge clk); check("bp_acc0", in_ready, 1); tick();
        in_op = 3'd2;                                   // FFF0
        @(negedge clk); check("bp_acc1", in_ready, 1); tick();
        in_op = 3'd4;                                   // 0FF0, refused while stalled
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp_full_in_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_y", out_y, 16'hF000);
            tick();
        end
        // full pipe: deliver and accept in the same cycle
        out_ready = 1'b1;
        @(negedge clk);
        check("pt_in_ready", in_ready, 1);
        check("pt_out_y", out_y, 16'hF000);
        tick();
        // occupancy still 2: stalled again, input must be refused
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("pt_occupancy", in_ready, 0);
        check("pt_out_y2", out_y, 16'hFFF0);
        tick();
        out_ready = 1'b1;
        @(negedge clk); check("bp_drain0", out_y, 16'hFFF0); tick();
        @(negedge clk); check("bp_drain1_v", out_valid, 1); check("bp_drain1", out_y, 16'h0FF0); tick();
        @(negedge clk);
        check("bp_empty", out_valid, 0);
        check("bp_op_count", op_count, 11);
        tick();

        // ---------------- reset mid-stream ----------------
        in_valid = 1'b1; in_op = 3'd6;
        tick();
        in_op = 3'd7;
        tick();
        reset = 1'b1; out_ready = 1'b0; in_op = 3'd0;  // pipe full; in_valid ignored
        @(negedge clk);
        check("mr_in_ready_in_reset", in_ready, 1);
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("mr_out_valid", out_valid, 0);
        check("mr_out_y", out_y, 0);
        check("mr_op_count", op_count, 0);
        check("mr_in_ready", in_ready, 1);
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mr_flushed", out_valid, 0);
            tick();
        end

        // ---------------- counter wrap (CNT_W=4 instance) ----------------
        reset = 1'b1; tick(); reset = 1'b0;
        in_op = 3'd3;
        for (int c = 0; c < 21; c++) begin
            int done;
            in_valid = (c < 17);
            done = (c < 2) ? 0 : ((c - 2 > 17) ? 17 : c - 2);
            @(negedge clk);
            check("cw_op_count16", op_count, done);
            check("cw_op_count4", op_count_c, done % 16);
            tick();
        end

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        // ---------------- flags ----------------
        in_a = 16'h00FF; in_b = 16'hFF00;
        in_valid = 1'b1; in_op = 3'd1;
        tick();
        in_op = 3'd0;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_and_y", out_y, 16'h0000);
        check("fl_and_zero", out_zero, 1);
        check("fl_and_ones", out_ones, 0);
        tick();
        @(negedge clk);
        check("fl_nand_y", out_y, 16'hFFFF);
        check("fl_nand_zero", out_zero, 0);
        check("fl_nand_ones", out_ones, 1);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised successor to the single-bit NAND primitive: a WIDTH-bit bitwise logic unit with op select and a STAGES-deep elastic valid/ready pipeline.
- Feeds wider ALU/datapath experiments in the Hack build where results must be registered and back-pressured.
- NAND remains op 0, so the block is a drop-in registered replacement for arrays of NAND instances.

Parameters:
- WIDTH, 16, operand and result width in bits (1..64).
- STAGES, 2, number of pipeline register stages (1..4); this is the latency with no stall.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a valid operation.
- in_ready  out  1  block accepts the operation this cycle.
- in_op  in  3  operation select (see Behaviour).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result valid at output stage.
- out_ready  in  1  downstream accepts the result this cycle.
- out_y  out  WIDTH  result.
- op_count  out  CNT_W  number of results delivered (out_valid & out_ready) since reset.

Behaviour:
- Op encoding, all bitwise:
  - 0: ~(a&b)
  - 1: a&b
  - 2: a|b
  - 3: ~(a|b)
  - 4: a^b
  - 5: ~(a^b)
  - 6: ~a (b ignored)
  - 7: a (pass)
- Result is computed combinationally from in_a/in_b/in_op and captured into stage 0 on accept. Stages 1..STAGES-1 only shift registered data.
- Accept condition: in_valid & in_ready. Deliver condition: out_valid & out_ready.
- Each stage k holds valid_k and data_k. Stage k loads from its predecessor when ~valid_k | ready_{k+1}, where ready_{STAGES} = out_ready.
- in_ready = ~valid_0 | ready_1. It is combinational from out_ready through the stages; there is no combinational path from in_valid to in_ready.
- Bubbles collapse: an empty stage always loads, so a stalled output does not block filling of earlier empty stages.
- Throughput: one op per cycle while out_ready = 1. Latency = STAGES cycles from accept to out_valid.
- While out_valid & ~out_ready, out_y and out_valid are held stable; no data is dropped or duplicated.
- A full pipe (all STAGES valid) with out_ready = 0 gives in_ready = 0.
- Simultaneous deliver at the output and accept at the input in the same cycle with a full pipe is allowed: every stage shifts by one.
- op_count increments by 1 on each deliver and wraps from 2^CNT_W-1 to 0 with no flag.
- Reset:
  - All valid_k = 0, all data_k = 0, op_count = 0.
  - Outputs after reset: out_valid = 0, out_y = 0, in_ready = 1.
  - Reset asserted mid-stream discards all in-flight ops. in_valid is ignored during reset.
  - in_ready reads 1 while reset is high, but no accept occurs.
- out_y is taken directly from the last stage register; no output combinational logic.

Optional Feature:
- Macro: LOGIC_UNIT_PIPE_FLAGS_EN.
- Defined:
  - Adds outputs out_zero (1 bit) and out_ones (1 bit), registered alongside data through every stage.
  - out_zero = (result == 0); out_ones = (result == all ones).
  - Both follow the same valid/hold rules as out_y and reset to 0.
- Undefined: the ports do not exist and no flag logic is synthesised.

Test Plan:
- Truth table, WIDTH=16, STAGES=2, out_ready=1:
  - Stimulus: a=16'hF0F0, b=16'hFF00, ops 0..7 back-to-back.
  - Required out_y on cycles 2..9: 0FFF, F000, FFF0, 000F, 0FF0, F00F, 0F0F, F0F0.
  - op_count = 8 afterwards.
- Back-pressure:
  - Stimulus: out_ready=0, then 3 ops offered every cycle.
  - Required: exactly 2 accepted (STAGES=2), then in_ready=0. out_y holds the first result unchanged while stalled.
  - Raise out_ready: results emerge in order, 1 per cycle, none lost.
- Full-pipe pass-through:
  - Stimulus: pipe full, out_ready=1 and in_valid=1 in the same cycle.
  - Required: one deliver and one accept in that cycle; occupancy stays 2.
- Reset mid-stream:
  - Stimulus: 2 ops in flight, assert reset for 1 cycle.
  - Required next cycle: out_valid=0, out_y=0, op_count=0, in_ready=1. Flushed ops never appear.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 delivered ops.
  - Required: op_count reads 15 after 15 delivers, 0 after 16, 1 after 17.
- Flags (LOGIC_UNIT_PIPE_FLAGS_EN defined):
  - op 1 with a=16'h00FF, b=16'hFF00 -> out_y=0000, out_zero=1, out_ones=0.
  - op 0 with the same operands -> out_y=FFFF, out_zero=0, out_ones=1.
